sfifo_buf: RTL and testbench
============================

Name: sfifo_buf

Overview:
- Single-clock show-ahead synchronous FIFO that buffers 16-bit motion/IO command words from the host-side writer.
- Feeds the SFIFO consumer in the WISHBONE interface block: its empty flag and head word drive that block's sfifo_empty_i / sfifo_di, and that block's read strobe drives rd_i.
- Provides level, almost-full and sticky overflow/underflow status so the writer can pace itself and firmware can detect loss.

Parameters:
- DW, 16, data word width; must equal the consumer's SFIFO_DW.
- AW, 4, address width; DEPTH = 2**AW words (16).
- AFULL_TH, 12, afull_o asserts when level >= AFULL_TH; legal range 1..DEPTH.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- clr_i  in  1  synchronous flush; empties the FIFO and clears the sticky flags.
- wr_i  in  1  write strobe; one word per cycle while high.
- wr_data_i  in  DW  write data.
- full_o  out  1  level == DEPTH.
- afull_o  out  1  level >= AFULL_TH.
- rd_i  in  1  pop strobe from the consumer (its sfifo_rd_o).
- empty_o  out  1  level == 0 (drives consumer sfifo_empty_i).
- rd_data_o  out  DW  head word, valid whenever empty_o=0 (drives consumer sfifo_di).
- level_o  out  AW+1  number of stored words, 0..DEPTH.
- ovf_o  out  1  sticky: a write was attempted while full.
- udf_o  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (async assert, sync-safe release): wr_ptr=0, rd_ptr=0, level=0, empty_o=1, full_o=0, afull_o=0, ovf_o=0, udf_o=0. rd_data_o is don't-care while empty; memory contents are not reset.
- Storage: DEPTH x DW register array; pointers are AW bits wide and wrap modulo DEPTH naturally. level_o is a separate AW+1-bit up/down counter.
- Accepted write: wr_i & ~full_o. The word is stored at wr_ptr, wr_ptr+1.
- Accepted pop: rd_i & ~empty_o. rd_ptr+1.
- Level update:
  - write only: +1
  - pop only: -1
  - both accepted: unchanged, both pointers advance
- Flags are derived combinationally from the registered level:
  - empty_o = (level==0)
  - full_o = (level==DEPTH)
  - afull_o = (level>=AFULL_TH)
- Show-ahead: rd_data_o = mem[rd_ptr] (asynchronous array read, no output register).
- Write-to-read latency: a word written at edge N is visible with empty_o=0 after edge N, so the consumer can see it in cycle N+1. There is no same-cycle bypass.
- Pop latency: after the pop edge, rd_data_o shows the next word, or empty_o rises if that was the last word.
- Boundary conditions:
  - Full & wr_i & rd_i: the pop is accepted; the write is rejected (uses the registered full flag); ovf_o is set.
  - Empty & wr_i & rd_i: the write is accepted; the pop is rejected; udf_o is set.
  - Write while full: data is dropped, pointers unchanged, ovf_o is set and held.
  - Pop while empty: no state change, udf_o is set and held.
  - Wrap-around: pointer at DEPTH-1 increments to 0; data order is preserved across the wrap.
  - clr_i has priority over simultaneous wr_i/rd_i. Next cycle: pointers=0, level=0, ovf_o=0, udf_o=0. Strobes in that cycle are ignored and do not set flags.
  - Reset mid-operation: immediate return to reset values; pending words are lost.
- Consumer contract: rd_i is a single-cycle pulse per word. A held rd_i pops one word per cycle.

Decomposition:
- Shared package holds:
  - SFIFO_DW (16), shared with the WISHBONE interface block
  - SFIFO_AW default (4)
  - SFIFO_AFULL_TH default (12)
- One natural sub-module: sfifo_mem, the DEPTH x DW register array with a synchronous write port and an asynchronous read port. Pointer, level and flag logic stay in sfifo_buf.

Test Plan:
- Reset then idle: empty_o=1, level_o=0, full_o=afull_o=ovf_o=udf_o=0. Write 0x1234 -> next cycle empty_o=0, rd_data_o=0x1234, level_o=1.
- Fill: write 0x0000..0x000F on 16 consecutive cycles.
  - afull_o rises after the 12th write.
  - full_o rises after the 16th write, level_o=16.
  - A 17th write of 0xDEAD -> ovf_o=1, level_o stays 16, 0xDEAD never appears on pop.
- Drain: 16 consecutive rd_i pulses read out 0x0000..0x000F in order, then empty_o=1. An extra rd_i sets udf_o=1 with level_o=0.
- Wrap plus simultaneous traffic:
  - Preload 10 words, then assert wr_i and rd_i together for 20 cycles.
  - level_o stays 10 throughout.
  - Output order matches the input order across the pointer wrap.
- Corner strobes:
  - Full with wr_i&rd_i: level 16 -> 15, ovf_o=1.
  - Empty with wr_i&rd_i: level 0 -> 1, udf_o=1, rd_data_o equals the written word.
- Flush/reset:
  - With 5 words stored, ovf_o=1, and clr_i plus wr_i asserted: next cycle level_o=0, empty_o=1, ovf_o=0.
  - Repeat the fill with wb_rst_i asserted mid-cycle: outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sfifo_buf_pkg.sv
// rtl/sfifo_buf_pkg.sv - shared widths and defaults for the SFIFO command buffer
package sfifo_buf_pkg;

    localparam int SFIFO_DW       = 16;
    localparam int SFIFO_AW       = 4;
    localparam int SFIFO_AFULL_TH = 12;

    typedef logic [SFIFO_DW-1:0] sfifo_word_t;

endpackage

// File: rtl/sfifo_mem.sv
// rtl/sfifo_mem.sv - DEPTH x DW register array, synchronous write, asynchronous read
module sfifo_mem #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          wb_clk_i,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [1<<AW];

    // Contents are deliberately not reset; the empty flag masks stale words.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sfifo_buf.sv
// rtl/sfifo_buf.sv - show-ahead single-clock FIFO feeding the WISHBONE SFIFO consumer
module sfifo_buf
    import sfifo_buf_pkg::*;
#(
    parameter int DW       = SFIFO_DW,
    parameter int AW       = SFIFO_AW,
    parameter int AFULL_TH = SFIFO_AFULL_TH
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          clr_i,
    input  logic          wr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          full_o,
    output logic          afull_o,
    input  logic          rd_i,
    output logic          empty_o,
    output logic [DW-1:0] rd_data_o,
    output logic [AW:0]   level_o,
    output logic          ovf_o,
    output logic          udf_o
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] DEPTH_LV = DEPTH[AW:0];
    localparam logic [AW:0] AFULL_LV = AFULL_TH[AW:0];
    localparam logic [AW:0] LVL_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          wr_ok;
    logic          rd_ok;

    assign empty_o = (level == '0);
    assign full_o  = (level == DEPTH_LV);
    assign afull_o = (level >= AFULL_LV);
    assign level_o = level;

    // Acceptance uses the registered flags, so a full FIFO still pops but refuses the write.
    assign wr_ok = wr_i & ~full_o & ~clr_i;
    assign rd_ok = rd_i & ~empty_o & ~clr_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf_o  <= 1'b0;
            udf_o  <= 1'b0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf_o  <= 1'b0;
            udf_o  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            if (wr_i && full_o) begin
                ovf_o <= 1'b1;
            end
            if (rd_i && empty_o) begin
                udf_o <= 1'b1;
            end
        end
    end

    sfifo_mem #(
        .DW (DW),
        .AW (AW)
    ) u_mem (
        .wb_clk_i (wb_clk_i),
        .wr_en    (wr_ok),
        .wr_addr  (wr_ptr),
        .wr_data  (wr_data_i),
        .rd_addr  (rd_ptr),
        .rd_data  (rd_data_o)
    );

endmodule

// File: tb/tb_sfifo_buf.sv
// tb/tb_sfifo_buf.sv - self-checking bench for sfifo_buf against a queue model
module tb_sfifo_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] wdata = '0;
    logic        rd = 1'b0;
    logic        full_o, afull_o, empty_o, ovf_o, udf_o;
    logic [15:0] rd_data_o;
    logic [4:0]  level_o;

    int          passed = 0;
    int          total = 0;
    logic [15:0] q[$];
    bit          m_ovf = 0;
    bit          m_udf = 0;

    always #5 clk = ~clk;

    sfifo_buf dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .clr_i     (clr),
        .wr_i      (wr),
        .wr_data_i (wdata),
        .full_o    (full_o),
        .afull_o   (afull_o),
        .rd_i      (rd),
        .empty_o   (empty_o),
        .rd_data_o (rd_data_o),
        .level_o   (level_o),
        .ovf_o     (ovf_o),
        .udf_o     (udf_o)
    );

    // One clock edge: advance the reference queue from the strobes held before the edge.
    task automatic tick();
        bit was_full, was_empty;
        @(posedge clk);
        if (rst || clr) begin
            q.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            was_full  = (q.size() == 16);
            was_empty = (q.size() == 0);
            if (rd && !was_empty) void'(q.pop_front());
            if (wr && !was_full) q.push_back(wdata);
            if (wr && was_full) m_ovf = 1;
            if (rd && was_empty) m_udf = 1;
        end
        #1;
    endtask

    task automatic drive(input bit w, input bit r, input logic [15:0] d);
        wr = w;
        rd = r;
        wdata = d;
        tick();
        wr = 0;
        rd = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        total++;
        if ({empty_o, full_o, afull_o, ovf_o, udf_o, level_o} !== {5'b10000, 5'd0})
            $display("FAIL reset_state got=%b exp=%b", {empty_o, full_o, afull_o, ovf_o, udf_o, level_o}, {5'b10000, 5'd0});
        else passed++;
        rst = 0;
        drive(1, 0, 16'h1234);
        total++;
        if ({empty_o, rd_data_o, level_o} !== {1'b0, 16'h1234, 5'd1})
            $display("FAIL first_write got=%b/%h/%0d exp=0/1234/1", empty_o, rd_data_o, level_o);
        else passed++;
        drive(0, 1, '0);
        total++;
        if (empty_o !== 1'b1) $display("FAIL first_pop_empty got=%b exp=1", empty_o);
        else passed++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 16'(i));
            total++;
            if ({afull_o, full_o, level_o} !== {(i + 1 >= 12), (i + 1 == 16), 5'(i + 1)})
                $display("FAIL fill_flags[%0d] got=%b/%b/%0d exp=%b/%b/%0d", i, afull_o, full_o, level_o,
                         (i + 1 >= 12), (i + 1 == 16), i + 1);
            else passed++;
        end
        drive(1, 0, 16'hDEAD);
        total++;
        if ({ovf_o, full_o, level_o} !== {2'b11, 5'd16})
            $display("FAIL overflow got=%b/%b/%0d exp=1/1/16", ovf_o, full_o, level_o);
        else passed++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            total++;
            if (rd_data_o !== 16'(i)) $display("FAIL drain_data[%0d] got=%h exp=%h", i, rd_data_o, 16'(i));
            else passed++;
            drive(0, 1, '0);
        end
        total++;
        if (empty_o !== 1'b1 || level_o !== 5'd0) $display("FAIL drain_empty got=%b/%0d exp=1/0", empty_o, level_o);
        else passed++;
        drive(0, 1, '0);
        total++;
        if ({udf_o, level_o} !== {1'b1, 5'd0}) $display("FAIL underflow got=%b/%0d exp=1/0", udf_o, level_o);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [15:0] d;
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 10; i++) drive(1, 0, 16'($urandom));
        for (int i = 0; i < 20; i++) begin
            d = 16'($urandom);
            total++;
            if (rd_data_o !== q[0]) $display("FAIL wrap_data[%0d] got=%h exp=%h", i, rd_data_o, q[0]);
            else passed++;
            drive(1, 1, d);
            total++;
            if (level_o !== 5'd10) $display("FAIL wrap_level[%0d] got=%0d exp=10", i, level_o);
            else passed++;
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (rd_data_o !== q[0]) $display("FAIL wrap_drain[%0d] got=%h exp=%h", i, rd_data_o, q[0]);
            else passed++;
            drive(0, 1, '0);
        end
    endtask

    task automatic test_corner();
        logic [15:0] d;
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 16; i++) drive(1, 0, 16'($urandom));
        drive(1, 1, 16'hBEEF);
        total++;
        if ({level_o, ovf_o} !== {5'd15, 1'b1}) $display("FAIL full_wr_rd got=%0d/%b exp=15/1", level_o, ovf_o);
        else passed++;
        clr = 1;
        tick();
        clr = 0;
        d = 16'($urandom);
        drive(1, 1, d);
        total++;
        if ({level_o, udf_o, rd_data_o} !== {5'd1, 1'b1, d})
            $display("FAIL empty_wr_rd got=%0d/%b/%h exp=1/1/%h", level_o, udf_o, rd_data_o, d);
        else passed++;
    endtask

    task automatic test_flush();
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 17; i++) drive(1, 0, 16'($urandom));
        for (int i = 0; i < 11; i++) drive(0, 1, '0);
        total++;
        if ({level_o, ovf_o} !== {5'd5, 1'b1}) $display("FAIL flush_setup got=%0d/%b exp=5/1", level_o, ovf_o);
        else passed++;
        clr = 1;
        drive(1, 0, 16'h5555);
        clr = 0;
        total++;
        if ({level_o, empty_o, ovf_o, udf_o} !== {5'd0, 3'b100})
            $display("FAIL flush got=%0d/%b/%b/%b exp=0/1/0/0", level_o, empty_o, ovf_o, udf_o);
        else passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 17; i++) drive(1, 0, 16'(i));
        #2;
        rst = 1;
        #1;
        q.delete();
        m_ovf = 0;
        m_udf = 0;
        total++;
        if ({empty_o, full_o, afull_o, ovf_o, udf_o, level_o} !== {5'b10000, 5'd0})
            $display("FAIL async_reset got=%b exp=%b", {empty_o, full_o, afull_o, ovf_o, udf_o, level_o}, {5'b10000, 5'd0});
        else passed++;
        tick();
        rst = 0;
    endtask

    task automatic test_random();
        logic [9:0] exp_v;
        for (int i = 0; i < 400; i++) begin
            clr = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 16'($urandom));
            clr = 0;
            exp_v = {q.size() == 0, q.size() == 16, q.size() >= 12, m_ovf, m_udf, 5'(q.size())};
            total++;
            if ({empty_o, full_o, afull_o, ovf_o, udf_o, level_o} !== exp_v)
                $display("FAIL random_state[%0d] got=%b exp=%b", i, {empty_o, full_o, afull_o, ovf_o, udf_o, level_o}, exp_v);
            else passed++;
            if (q.size() != 0) begin
                total++;
                if (rd_data_o !== q[0]) $display("FAIL random_head[%0d] got=%h exp=%h", i, rd_data_o, q[0]);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_corner();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
